framer_8b10b_tx: RTL and testbench

FRAMER_8B10B_TX -- requirements
Module: framer_8b10b_tx

---
 rtl/pkg_8b10b.sv | 8 +
 rtl/framer_8b10b_tx_if.sv | 13 +
 rtl/framer_8b10b_tx.sv | 91 +++++++++
 tb/tb_framer_8b10b_tx.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pkg_8b10b.sv
// pkg_8b10b: K-code symbol bytes and framer state encoding shared by the 8b10b transmit path.
package pkg_8b10b;
   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K23_7 = 8'hF7;
   typedef enum logic [1:0] {IDLE, DATA, EOF, DROP} state_t;
endpackage

// File: rtl/framer_8b10b_tx_if.sv
// framer_8b10b_tx_if: source byte stream in, symbol stream out toward the encoder.
interface framer_8b10b_tx_if;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       s_last;
   logic       dvo;
   logic       k;
   logic [7:0] dout;
   logic       err;
   modport master (output s_valid, s_data, s_last, input s_ready, dvo, k, dout, err);
   modport slave (input s_valid, s_data, s_last, output s_ready, dvo, k, dout, err);
endinterface

// File: rtl/framer_8b10b_tx.sv
// framer_8b10b_tx: wraps a byte stream into SOF/data/EOF symbol frames with K28.5 idle fill
// and truncates frames longer than MAX_LEN, draining the remainder.
module framer_8b10b_tx
   import pkg_8b10b::*;
#(
   parameter int MIN_IDLE = 2,
   parameter int MAX_LEN  = 256
) (
   input logic              clk,
   input logic              rst,
   input logic              en,
   framer_8b10b_tx_if.slave bus
);
   state_t      state, state_n;
   logic [7:0]  idle_cnt, idle_n, idle_inc, dout_n;
   logic [15:0] len_cnt, len_n;
   logic        abort, abort_n, k_n, err_n, acc, last_len;
   assign bus.s_ready = state == DROP || (state == DATA && en);
   assign acc         = bus.s_valid && bus.s_ready;
   assign last_len    = {1'b0, len_cnt} + 17'd1 == 17'(MAX_LEN);
   assign idle_inc    = idle_cnt == 8'hFF ? idle_cnt : idle_cnt + 8'd1;
   always_comb begin
      state_n = state;
      idle_n  = idle_cnt;
      len_n   = len_cnt;
      abort_n = abort;
      k_n     = bus.k;
      dout_n  = bus.dout;
      err_n   = 1'b0;
      if (en)
         case (state)
            IDLE: begin
               k_n = 1'b1;
               if (bus.s_valid && idle_cnt >= 8'(MIN_IDLE)) begin
                  dout_n  = K27_7;
                  len_n   = '0;
                  state_n = DATA;
               end else begin
                  dout_n = K28_5;
                  idle_n = idle_inc;
               end
            end
            DATA: begin
               k_n    = !acc;
               dout_n = acc ? bus.s_data : K23_7;
               len_n  = acc ? len_cnt + 16'd1 : len_cnt;
               // a last byte landing exactly on MAX_LEN is a clean end, not a truncation
               if (acc && (bus.s_last || last_len)) begin
                  state_n = EOF;
                  abort_n = !bus.s_last;
               end
            end
            EOF: begin
               k_n     = 1'b1;
               dout_n  = K29_7;
               idle_n  = '0;
               err_n   = abort;
               abort_n = 1'b0;
               state_n = abort ? DROP : IDLE;
            end
            DROP: begin
               k_n    = 1'b1;
               dout_n = K28_5;
               idle_n = idle_inc;
            end
         endcase
      // draining ignores the slot strobe so the source is never stalled
      if (state == DROP && acc && bus.s_last) state_n = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idle_cnt <= '0;
         len_cnt  <= '0;
         abort    <= 1'b0;
         bus.dvo  <= 1'b0;
         bus.k    <= 1'b0;
         bus.dout <= '0;
         bus.err  <= 1'b0;
      end else begin
         state    <= state_n;
         idle_cnt <= idle_n;
         len_cnt  <= len_n;
         abort    <= abort_n;
         bus.dvo  <= en;
         bus.k    <= k_n;
         bus.dout <= dout_n;
         bus.err  <= err_n;
      end
   end
endmodule

// File: tb/tb_framer_8b10b_tx.sv
// tb_framer_8b10b_tx: directed frames with a queued expected symbol stream checked by a monitor.
module tb_framer_8b10b_tx;
   logic       clk = 1'b0, rst = 1'b1, en = 1'b0, alt = 1'b0;
   logic       r, e, pk;
   logic [7:0] pd;
   logic [9:0] x;
   logic [9:0] exp_q[$];
   int         checks = 0, errors = 0;
   bit         mon_on = 1'b0;
   framer_8b10b_tx_if bus ();
   framer_8b10b_tx #(.MIN_IDLE(2), .MAX_LEN(4)) dut (.clk(clk), .rst(rst), .en(en), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, req);
      end
   endtask
   function automatic void push(input logic k, input logic [7:0] d, input logic er = 1'b0);
      exp_q.push_back({k, er, d});
   endfunction
   function automatic void push_data(input logic [7:0] d);
      push(1'b0, d);
   endfunction
   task automatic tick();
      @(negedge clk);
      en = alt ? ~en : 1'b1;
   endtask
   task automatic send(input logic [7:0] d, input logic last);
      for (int i = 0; i < 50; i++) begin
         tick();
         bus.s_valid = 1'b1;
         bus.s_data  = d;
         bus.s_last  = last;
         #1;
         if (alt && !en) check("s_ready_en0", 10'(bus.s_ready), 10'd0);
         if (bus.s_ready) return;
      end
      checks++;
      errors++;
      $display("FAIL send_timeout byte %h never accepted", d);
   endtask
   task automatic gap(input int n);
      repeat (n) begin
         tick();
         bus.s_valid = 1'b0;
      end
   endtask
   initial forever begin
      @(posedge clk);
      r = rst;
      e = en;
      #1;
      if (r) begin
         check("rst_dvo", 10'(bus.dvo), 10'd0);
         check("rst_out", {bus.k, bus.err, bus.dout}, 10'd0);
         mon_on = 1'b1;
      end else if (mon_on) begin
         check("dvo_vs_en", 10'(bus.dvo), 10'(e));
         if (bus.dvo) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_symbol got k=%b d=%h want none", bus.k, bus.dout);
            end else begin
               x = exp_q.pop_front();
               check("symbol", {bus.k, bus.err, bus.dout}, x);
            end
         end else check("hold", {bus.k, bus.err, bus.dout}, {pk, 1'b0, pd});
      end
      pk = bus.k;
      pd = bus.dout;
   end
   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1);
   end
   initial begin
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      en          = 1'b1;
      repeat (2) @(negedge clk);
      // frame 1: two idles after reset, SOF, 3 bytes, EOF
      push(1, 8'hBC); push(1, 8'hBC); push(1, 8'hFB);
      push_data(8'h11); push_data(8'h22); push_data(8'h33); push(1, 8'hFD);
      // frame 2 back-to-back: exactly two idles, two fillers, last byte on MAX_LEN is clean
      push(1, 8'hBC); push(1, 8'hBC); push(1, 8'hFB); push_data(8'hA1);
      push(1, 8'hF7); push(1, 8'hF7);
      push_data(8'hA2); push_data(8'hA3); push_data(8'hA4); push(1, 8'hFD);
      // frame 3 oversize: 4 bytes, EOF with ERR, two drained bytes emit idles
      push(1, 8'hBC); push(1, 8'hBC); push(1, 8'hFB);
      push_data(8'hB1); push_data(8'hB2); push_data(8'hB3); push_data(8'hB4);
      push(1, 8'hFD, 1'b1); push(1, 8'hBC); push(1, 8'hBC);
      // frame 4 with EN on alternate cycles
      push(1, 8'hFB); push_data(8'hC1); push_data(8'hC2); push(1, 8'hFD);
      // frame 5 abandoned by reset, then idles only
      push(1, 8'hBC); push(1, 8'hBC); push(1, 8'hFB); push_data(8'hD1); push_data(8'hD2);
      repeat (5) push(1, 8'hBC);
      rst = 1'b0;
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
      send(8'hA1, 0); gap(2); send(8'hA2, 0); send(8'hA3, 0); send(8'hA4, 1);
      send(8'hB1, 0); send(8'hB2, 0); send(8'hB3, 0); send(8'hB4, 0);
      send(8'hB5, 0); send(8'hB6, 1);
      alt = 1'b1;
      send(8'hC1, 0); send(8'hC2, 1);
      alt = 1'b0;
      send(8'hD1, 0); send(8'hD2, 0);
      tick();
      rst         = 1'b1;
      bus.s_valid = 1'b0;
      tick();
      rst = 1'b0;
      gap(4);
      @(negedge clk);
      en = 1'b0;
      repeat (4) @(negedge clk);
      check("queue_empty", 10'(exp_q.size()), 10'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
